input_controls: RTL

Input stage directly upstream of `statemachine`. Two players each own four buttons, for eight raw inputs driven from `iSW[7:0]`. Each input is synchronized to the 108 MHz pixel clock and debounced. Press edges are latched, and once per frame the block presents a registered snapshot on `controller1`/`controller2`. The state machine reads that snapshot and never sees a press shorter than one frame get lost.

---
 rtl/console_pkg.sv | 21 ++
 rtl/debounce_bit.sv | 46 ++++
 rtl/input_controls.sv | 68 ++++++
 3 files changed

// File: rtl/console_pkg.sv
// Button indices and controller-byte field layout. The input stage and the
// state machine both use these, so they agree on the byte layout.
package console_pkg;
   localparam int BTN_LEFT    = 0;
   localparam int BTN_RIGHT   = 1;
   localparam int BTN_JUMP    = 2;
   localparam int BTN_ATTACK  = 3;
   localparam int N_BTN       = 4;
   localparam int HELD_LSB    = 0;
   localparam int PRESSED_LSB = 4;

   typedef logic [N_BTN-1:0] btn_t;

   function automatic logic [7:0] pack_ctrl(input btn_t pressed, input btn_t held);
      logic [7:0] v;
      v = '0;
      v[PRESSED_LSB +: N_BTN] = pressed;
      v[HELD_LSB +: N_BTN]    = held;
      return v;
   endfunction
endpackage

// File: rtl/debounce_bit.sv
// One button: a two-flop synchronizer followed by a hold-time debouncer.
// rise flags the cycle on which stable is about to go from 0 to 1.
module debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 1080000,
   parameter int CNT_W           = 21
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic rise
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             w_at_max;

   assign w_at_max = (r_cnt == CNT_MAX);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_s1 <= raw;
         r_s2 <= r_s1;
         // Any return to the accepted level restarts the hold window.
         if (r_s2 == r_stable) begin
            r_cnt <= '0;
         end else if (w_at_max) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign stable = r_stable;
   assign rise   = r_s2 & ~r_stable & w_at_max;
endmodule

// File: rtl/input_controls.sv
// Eight debounced buttons with sticky press latches. Once per frame the
// controller bytes are snapshotted, so a press lasting less than a frame is kept.
module input_controls
   import console_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1080000,
   parameter int CNT_W           = 21
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] raw1,
   input  logic [3:0] raw2,
   input  logic       frame_tick,
   output logic [7:0] controller1,
   output logic [7:0] controller2,
   output logic       snap_valid
);
   localparam int N_ALL = 2 * N_BTN;

   logic [N_ALL-1:0] w_raw;
   logic [N_ALL-1:0] w_stable;
   logic [N_ALL-1:0] w_rise;
   logic [N_ALL-1:0] w_pressed;
   logic [N_ALL-1:0] r_press_latch;
   logic [7:0]       r_ctrl1;
   logic [7:0]       r_ctrl2;
   logic             r_snap_valid;

   assign w_raw = {raw2, raw1};

   for (genvar gi = 0; gi < N_ALL; gi++) begin : g_btn
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db (
         .clock (clock),
         .reset (reset),
         .raw   (w_raw[gi]),
         .stable(w_stable[gi]),
         .rise  (w_rise[gi])
      );
   end

   // Folding in the current-cycle rise lets a tick-coincident press be consumed once.
   assign w_pressed = r_press_latch | w_rise;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_press_latch <= '0;
         r_ctrl1       <= 8'h00;
         r_ctrl2       <= 8'h00;
         r_snap_valid  <= 1'b0;
      end else begin
         r_snap_valid <= frame_tick;
         if (frame_tick) begin
            r_ctrl1       <= pack_ctrl(w_pressed[N_BTN-1:0], w_stable[N_BTN-1:0]);
            r_ctrl2       <= pack_ctrl(w_pressed[N_ALL-1:N_BTN], w_stable[N_ALL-1:N_BTN]);
            r_press_latch <= '0;
         end else begin
            r_press_latch <= w_pressed;
         end
      end
   end

   assign controller1 = r_ctrl1;
   assign controller2 = r_ctrl2;
   assign snap_valid  = r_snap_valid;
endmodule
